// File: rtl/alu_bcd_converter.sv
// Sequential shift-add-3 (double-dabble) converter: signed ALU result in,
// sign-magnitude 3-digit BCD out, saturated at 999 with an overflow flag.
module alu_bcd_converter #(
  parameter int BIN_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] alu_result,
  output logic                 busy,
  output logic                 done,
  output logic [11:0]          bcd_out,
  output logic                 alu_sign,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] LAST_ITER = 4'(BIN_WIDTH - 1);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [BIN_WIDTH-1:0] mag_q, mag_d;
  logic [15:0]          scratch_q, scratch_d;
  logic                 sign_q, sign_d;
  logic [11:0]          bcd_q, bcd_d;
  logic                 out_sign_q, out_sign_d;
  logic                 ovf_q, ovf_d;

  logic                 accept;
  logic                 last_iter;
  logic [15:0]          adjusted;
  logic [BIN_WIDTH-1:0] abs_value;

  assign accept    = (state_q == ST_IDLE) && start;
  assign last_iter = (state_q == ST_CONV) && (cnt_q == LAST_ITER);

  // Two's-complement negate as unsigned: the most negative input maps onto
  // its own bit pattern, which read unsigned is exactly its magnitude.
  assign abs_value = alu_result[BIN_WIDTH-1] ? (~alu_result + 1'b1) : alu_result;

  // State register: the only place state is updated.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mag_q      <= '0;
      scratch_q  <= '0;
      sign_q     <= 1'b0;
      bcd_q      <= '0;
      out_sign_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      scratch_q  <= scratch_d;
      sign_q     <= sign_d;
      bcd_q      <= bcd_d;
      out_sign_q <= out_sign_d;
      ovf_q      <= ovf_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start)     state_d = ST_CONV;
      ST_CONV: if (last_iter) state_d = ST_DONE;
      ST_DONE:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Datapath: add-3 correction on every BCD nibble, then a joint left shift.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    adjusted   = scratch_q;
    scratch_d  = scratch_q;
    mag_d      = mag_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    bcd_d      = bcd_q;
    out_sign_d = out_sign_q;
    ovf_d      = ovf_q;

    for (int i = 0; i < 4; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end

    if (accept) begin
      sign_d    = alu_result[BIN_WIDTH-1];
      mag_d     = abs_value;
      scratch_d = '0;
      cnt_d     = '0;
    end else if (state_q == ST_CONV) begin
      scratch_d = {adjusted[14:0], mag_q[BIN_WIDTH-1]};
      mag_d     = {mag_q[BIN_WIDTH-2:0], 1'b0};
      cnt_d     = cnt_q + 4'd1;
    end

    // Outputs are loaded from the post-shift scratch on the edge into DONE;
    // a nonzero thousands digit is the same test as magnitude > 999.
    if (last_iter) begin
      out_sign_d = sign_q;
      if (scratch_d[15:12] != 4'd0) begin
        ovf_d = 1'b1;
        bcd_d = 12'h999;
      end else begin
        ovf_d = 1'b0;
        bcd_d = scratch_d[11:0];
      end
    end
  end

  // Output logic: all driven from registers only.
  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    bcd_out  = bcd_q;
    alu_sign = out_sign_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_alu_bcd_converter.sv
// Self-checking bench for alu_bcd_converter: directed scenarios plus random
// and exhaustive conversions against an arithmetic reference model.
module tb_alu_bcd_converter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [10:0] alu_result;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
  logic        alu_sign;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  alu_bcd_converter #(.BIN_WIDTH(11)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alu_result (alu_result),
    .busy       (busy),
    .done       (done),
    .bcd_out    (bcd_out),
    .alu_sign   (alu_sign),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: sign, magnitude by plain arithmetic, decimal digits by division.
  function automatic void ref_model(input logic [10:0] v, output logic [11:0] bcd,
                                    output logic sgn, output logic ovf);
    int sv, mag;
    sv  = int'($signed(v));
    mag = (sv < 0) ? -sv : sv;
    sgn = (sv < 0);
    ovf = (mag > 999);
    if (ovf) bcd = 12'h999;
    else     bcd = {4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept v, wait (bounded) for done, then step past the DONE cycle to IDLE.
  // lat = edges from accept to done; busy_cnt = busy samples from E0 to E12.
  task automatic run_conv(input logic [10:0] v, output int lat, output bit got,
                          output int busy_cnt);
    alu_result = v;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    alu_result = 11'($urandom);
    busy_cnt   = busy ? 1 : 0;
    lat        = 0;
    got        = 1'b0;
    while (lat < 20 && !got) begin
      tick();
      lat++;
      if (busy) busy_cnt++;
      if (done) got = 1'b1;
    end
    tick();
    if (busy) busy_cnt++;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    start      = 1'b1;
    alu_result = 11'd149;
    tick();
    tick();
    start = 1'b0;
    reset = 1'b0;
    total++;
    if ({busy, done, bcd_out, alu_sign, overflow} !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b bcd=%h sign=%b ovf=%b, want all 0",
               busy, done, bcd_out, alu_sign, overflow);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_drops_start: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    bit got;
    run_conv(11'd149, lat, got, bc);
    total++;
    if (!got || lat != 11) begin
      bad++;
      $display("FAIL basic_latency: got done=%b after %0d edges, want 11", got, lat);
    end
    total++;
    if (bcd_out !== 12'h149 || alu_sign !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL basic_value: got bcd=%h sign=%b ovf=%b, want 149 0 0",
               bcd_out, alu_sign, overflow);
    end
    total++;
    if (bc != 12 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy: got %0d busy cycles (busy now %b), want 12 then 0", bc, busy);
    end
  endtask

  task automatic test_signs();
    logic [10:0] vals [5] = '{11'h726, 11'd0, 11'd1023, 11'h400, 11'd999};
    int lat, bc;
    bit got;
    logic [11:0] eb;
    logic es, eo;
    for (int i = 0; i < 5; i++) begin
      run_conv(vals[i], lat, got, bc);
      ref_model(vals[i], eb, es, eo);
      total++;
      if (!got || bcd_out !== eb || alu_sign !== es || overflow !== eo) begin
        bad++;
        $display("FAIL signs_ovf[%h]: got done=%b bcd=%h sign=%b ovf=%b, want bcd=%h sign=%b ovf=%b",
                 vals[i], got, bcd_out, alu_sign, overflow, eb, es, eo);
      end
    end
  endtask

  task automatic test_start_during();
    int dones = 0;
    int lat, bc;
    bit got;
    alu_result = 11'd387;
    start      = 1'b1;
    tick();                      // E0
    start      = 1'b0;
    alu_result = 11'd5;
    for (int e = 1; e <= 11; e++) begin
      if (e == 4) start = 1'b1;  // high for edge E4
      tick();
      start = 1'b0;
      if (done) dones++;
    end
    start = 1'b1;                // high during the DONE cycle
    tick();                      // E12
    start = 1'b0;
    for (int e = 0; e < 16; e++) begin
      if (done) dones++;
      tick();
    end
    total++;
    if (dones != 1 || bcd_out !== 12'h387) begin
      bad++;
      $display("FAIL start_ignored: got %0d done pulses bcd=%h, want 1 and 387", dones, bcd_out);
    end
    run_conv(11'd5, lat, got, bc);
    total++;
    if (!got || bcd_out !== 12'h005 || alu_sign !== 1'b0) begin
      bad++;
      $display("FAIL start_after: got done=%b bcd=%h sign=%b, want 005 0", got, bcd_out, alu_sign);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, dones;
    bit got;
    run_conv(11'h400, lat, got, bc);   // leave non-zero outputs behind
    alu_result = 11'd642;
    start      = 1'b1;
    tick();                            // E0
    start = 1'b0;
    dones = 0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (done) dones++;
    end
    reset = 1'b1;
    tick();                            // E5
    reset = 1'b0;
    total++;
    if ({busy, done, bcd_out, alu_sign, overflow} !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid_clear: got busy=%b done=%b bcd=%h sign=%b ovf=%b, want all 0",
               busy, done, bcd_out, alu_sign, overflow);
    end
    for (int e = 0; e < 15; e++) begin
      tick();
      if (done) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL reset_mid_nodone: got %0d done pulses, want 0", dones);
    end
    run_conv(11'd642, lat, got, bc);
    total++;
    if (!got || lat != 11 || bcd_out !== 12'h642) begin
      bad++;
      $display("FAIL reset_mid_retry: got done=%b lat=%0d bcd=%h, want 11 and 642", got, lat, bcd_out);
    end
  endtask

  task automatic check_value(input logic [10:0] v, input string tag);
    int lat, bc;
    bit got;
    logic [11:0] eb;
    logic es, eo;
    run_conv(v, lat, got, bc);
    ref_model(v, eb, es, eo);
    total++;
    if (!got || lat != 11 || bcd_out !== eb || alu_sign !== es || overflow !== eo) begin
      bad++;
      $display("FAIL %s[%h]: got done=%b lat=%0d bcd=%h sign=%b ovf=%b, want 11 bcd=%h sign=%b ovf=%b",
               tag, v, got, lat, bcd_out, alu_sign, overflow, eb, es, eo);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) check_value(11'($urandom), "random");
  endtask

  task automatic test_back_to_back();
    for (int v = 0; v < 2048; v++) check_value(11'(v), "sweep");
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    alu_result = '0;
    #1;
    test_reset();
    test_basic();
    test_signs();
    test_start_during();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
